// File: rtl/l2_mem_pkg.sv
// Shared types for the L2/memory arbiter: FSM state encoding, op encoding, default widths.
package l2_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/l2_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward, wrapping.
module rr_pick #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_CH-1:0]  gnt_oh,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int unsigned      cand;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand     = (32'(rr_ptr) + k) % N_CH;
            cand_idx = PTR_W'(cand);
            if (!gnt_any && req[cand_idx]) begin
                gnt_any          = 1'b1;
                gnt_oh[cand_idx] = 1'b1;
                gnt_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/l2_mem_arbiter.sv
// N-channel round-robin line arbiter onto a single memory port; one transaction in flight.
module l2_mem_arbiter
    import l2_mem_pkg::*;
#(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [PTR_W-1:0]  rr_ptr_q, gnt_q, pick_idx;
    logic [N_CH-1:0]   gnt_oh_q, pick_oh, req;
    logic              pick_any;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [LINE_W-1:0] wdata_q, rdata_q, sel_wdata;
    logic              sel_wr;

    assign req = ch_read | ch_write;

    rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // One-hot AND-OR select keeps the channel mux free of variable-width indexing.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (pick_oh[i]) begin
                sel_addr  = sel_addr  | ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | ch_wdata[i*LINE_W +: LINE_W];
                sel_wr    = sel_wr    | ch_write[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ch_ready  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) state_d = ISSUE;
            end
            ISSUE: begin
                mem_read  = (op_q == OP_READ);
                mem_write = (op_q == OP_WRITE);
                if (mem_ready) state_d = RESP;
            end
            RESP: begin
                ch_ready = gnt_oh_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (state_q == IDLE && pick_any) begin
                gnt_q    <= pick_idx;
                gnt_oh_q <= pick_oh;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
                op_q     <= sel_wr ? OP_WRITE : OP_READ;
            end
            if (state_q == ISSUE && mem_ready && op_q == OP_READ) begin
                rdata_q <= mem_rdata;
            end
            if (state_q == RESP) begin
                rr_ptr_q <= (gnt_q == PTR_W'(N_CH - 1)) ? '0 : gnt_q + PTR_W'(1);
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ch_rdata  = rdata_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter with four channels; memory side driven by hand.
module tb_l2_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 28;
    localparam int LW = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      ch_read = '0;
    logic [N-1:0]      ch_write = '0;
    logic [N*AW-1:0]   ch_addr = '0;
    logic [N*LW-1:0]   ch_wdata = '0;
    logic [LW-1:0]     ch_rdata;
    logic [N-1:0]      ch_ready;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [LW-1:0]     mem_wdata;
    logic [LW-1:0]     mem_rdata = '0;
    logic              mem_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [LW-1:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [LW-1:0] W1   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [LW-1:0] W2   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [LW-1:0] R1   = 128'hCAFEF00D_00000000_12345678_9ABCDEF0;

    l2_mem_arbiter #(
        .N_CH   (N),
        .ADDR_W (AW),
        .LINE_W (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_read   (ch_read),
        .ch_write  (ch_write),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_ready  (ch_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Waits for the strobe, checks the issued command, answers after lat cycles,
    // then checks the completion. Returns while the arbiter is in RESP.
    task automatic serve(input string tag, input int ch, input bit wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] wd,
                         input logic [LW-1:0] rd_mem, input logic [LW-1:0] rd_exp,
                         input int exp_wait, input int lat);
        int  waited = 0;
        bit  seen   = 1'b0;
        logic [N-1:0] exp_rdy;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            waited++;
            if (mem_read || mem_write) seen = 1'b1;
        end
        chk({tag, ".lat"}, LW'(waited), LW'(exp_wait));
        if (!seen) return;
        chk({tag, ".mwr"}, LW'(mem_write), LW'(wr));
        chk({tag, ".mrd"}, LW'(mem_read), LW'(!wr));
        chk({tag, ".addr"}, LW'(mem_addr), LW'(a));
        if (wr) chk({tag, ".wdata"}, mem_wdata, wd);
        repeat (lat) tick();
        chk({tag, ".hold"}, LW'(mem_addr), LW'(a));
        mem_rdata = rd_mem;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        exp_rdy = '0;
        exp_rdy[ch] = 1'b1;
        chk({tag, ".rdy"}, LW'(ch_ready), LW'(exp_rdy));
        chk({tag, ".rdata"}, ch_rdata, rd_exp);
        chk({tag, ".strb"}, LW'({mem_read, mem_write}), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk("rst.rdy",   LW'(ch_ready), '0);
        chk("rst.strb",  LW'({mem_read, mem_write}), '0);
        chk("rst.addr",  LW'(mem_addr), '0);
        chk("rst.wdata", mem_wdata, '0);
        chk("rst.rdata", ch_rdata, '0);
        rst_n = 1'b1;

        // single read on channel 0, memory answers after 5 ISSUE cycles
        ch_read[0] = 1'b1;
        ch_addr[0*AW +: AW] = 28'h0000010;
        serve("rd0", 0, 1'b0, 28'h0000010, '0, DEAD, DEAD, 1, 4);
        ch_read[0] = 1'b0;
        tick();
        chk("rd0.pulse", LW'(ch_ready), '0);

        // spurious mem_ready while idle
        mem_ready = 1'b1;
        tick();
        chk("spur.rdy",  LW'(ch_ready), '0);
        chk("spur.strb", LW'({mem_read, mem_write}), '0);
        tick();
        chk("spur.rdy2", LW'(ch_ready), '0);
        mem_ready = 1'b0;

        // read+write on one channel: write wins, rdata register untouched
        ch_read[2]  = 1'b1;
        ch_write[2] = 1'b1;
        ch_addr[2*AW +: AW]  = 28'h0000030;
        ch_wdata[2*LW +: LW] = W2;
        serve("both", 2, 1'b1, 28'h0000030, W2, 128'hBAD, DEAD, 1, 0);
        ch_read[2]  = 1'b0;
        ch_write[2] = 1'b0;
        tick();

        // simultaneous ch0 read and ch1 write straight after reset
        do_reset();
        ch_read[0]  = 1'b1;
        ch_addr[0*AW +: AW]  = 28'h0000010;
        ch_write[1] = 1'b1;
        ch_addr[1*AW +: AW]  = 28'h0000020;
        ch_wdata[1*LW +: LW] = W1;
        serve("sim0", 0, 1'b0, 28'h0000010, '0, R1, R1, 1, 1);
        ch_read[0] = 1'b0;
        serve("sim1", 1, 1'b1, 28'h0000020, W1, 128'h55, R1, 2, 0);
        ch_write[1] = 1'b0;
        tick();

        // all four channels requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) ch_addr[i*AW +: AW] = AW'(28'h100 + i);
        ch_read = '1;
        for (int k = 0; k < 5; k++) begin
            serve($sformatf("rr%0d", k), k % N, 1'b0, AW'(28'h100 + (k % N)), '0,
                  LW'(k + 1), LW'(k + 1), (k == 0) ? 1 : 2, 0);
        end

        // async reset during ISSUE; rr_ptr is 1 here before reset
        ch_read = 4'b1000;
        tick();
        tick();
        chk("ar.issue", LW'(mem_read), LW'(1));
        chk("ar.addr",  LW'(mem_addr), LW'(28'h103));
        ch_read = 4'b1001;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.drop", LW'(mem_read), '0);
        @(posedge clk);
        #1;
        chk("ar.rdy",  LW'(ch_ready), '0);
        chk("ar.strb", LW'({mem_read, mem_write}), '0);
        rst_n = 1'b1;
        serve("ar.g0", 0, 1'b0, 28'h100, '0, W1, W1, 1, 0);
        ch_read[0] = 1'b0;
        serve("ar.g3", 3, 1'b0, 28'h103, '0, W2, W2, 2, 0);
        ch_read = '0;
        tick();
        chk("end.rdy", LW'(ch_ready), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
